// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and default geometry for the cache/memory arbiter.
// The line_burst_buf helper sizes itself from parameters, not these constants.
package arb_types;
  localparam int LINE_W      = 256;
  localparam int BEAT_W      = 64;
  localparam int BEATS       = LINE_W / BEAT_W;
  localparam int OFFSET_BITS = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} arb_state_t;
  typedef enum logic {src_i, src_d} arb_src_t;
endpackage

// File: rtl/cache_mem_arbiter_line_burst_buf.sv
// Beat counter plus line assembly buffer for whole-line bursts.
// The same block is meant to sit behind the future L2 interface.
module line_burst_buf #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              beat_valid,
  input  logic              store_en,
  input  logic [BEAT_W-1:0] beat_in,
  input  logic [LINE_W-1:0] wline,
  output logic              last_beat,
  output logic [LINE_W-1:0] line_out,
  output logic [BEAT_W-1:0] beat_out
);
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);

  logic [CNT_W-1:0]  cnt_q;
  logic [LINE_W-1:0] line_q;

  // BEATS is a power of two, so the counter wraps to 0 after the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (beat_valid) begin
      if (store_en) line_q[int'(cnt_q)*BEAT_W +: BEAT_W] <= beat_in;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
  assign line_out  = line_q;
  assign beat_out  = wline[int'(cnt_q)*BEAT_W +: BEAT_W];
endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one burst memory port between I-cache (read) and D-cache (read/write).
// Optional macro ARB_FAIRNESS_EN alternates grants when both sides contend.
module cache_mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  import arb_types::*;

  localparam int OFF_W = $clog2(LINE_W / 8);

  arb_state_t        state_q;
  logic [ADDR_W-1:0] addr_q, addr_d, sel_addr;
  logic              rd_q, wr_q, i_resp_q, d_resp_q;
  logic              d_sel, any_req, in_burst, last_beat;
  arb_src_t          grant_src;
  logic [LINE_W-1:0] line_out;
`ifdef ARB_FAIRNESS_EN
  arb_src_t          last_grant_q;
`endif

  always_comb begin
    d_sel = d_read || d_write;
`ifdef ARB_FAIRNESS_EN
    if (i_read && d_sel) d_sel = (last_grant_q == src_i);
`endif
    grant_src = d_sel ? src_d : src_i;
    sel_addr  = d_sel ? d_addr : i_addr;
    addr_d    = {sel_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  end

  assign any_req  = i_read || d_read || d_write;
  assign in_burst = (state_q == I_RD) || (state_q == D_RD) || (state_q == D_WR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
`ifdef ARB_FAIRNESS_EN
      last_grant_q <= src_i;
`endif
    end else begin
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
      unique case (state_q)
        IDLE: if (any_req) begin
          addr_q <= addr_d;
`ifdef ARB_FAIRNESS_EN
          last_grant_q <= grant_src;
`endif
          // A write wins over a simultaneous D read (protocol error, flagged below).
          if (grant_src == src_i) begin
            state_q <= I_RD;
            rd_q    <= 1'b1;
          end else if (d_write) begin
            state_q <= D_WR;
            wr_q    <= 1'b1;
          end else begin
            state_q <= D_RD;
            rd_q    <= 1'b1;
          end
        end
        I_RD, D_RD, D_WR: if (pmem_resp && last_beat) begin
          state_q  <= DONE;
          rd_q     <= 1'b0;
          wr_q     <= 1'b0;
          i_resp_q <= (state_q == I_RD);
          d_resp_q <= (state_q != I_RD);
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  line_burst_buf #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .clr        (state_q == IDLE),
    .beat_valid (pmem_resp && in_burst),
    .store_en   (state_q != D_WR),
    .beat_in    (pmem_rdata),
    .wline      (d_wdata),
    .last_beat  (last_beat),
    .line_out   (line_out),
    .beat_out   (pmem_wdata)
  );

  assign pmem_read  = rd_q;
  assign pmem_write = wr_q;
  assign pmem_addr  = addr_q;
  assign i_resp     = i_resp_q;
  assign d_resp     = d_resp_q;
  assign i_rdata    = line_out;
  assign d_rdata    = line_out;

  assert property (@(posedge clk) disable iff (rst) (state_q == IDLE) |-> !(d_read && d_write))
    else $warning("cache_mem_arbiter: d_read and d_write asserted together, serving the write");
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: expectations queued in service order,
// checked per memory beat and at every resp pulse.
module tb_cache_mem_arbiter;
  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int ADDR_W = 32;
  localparam int BEATS  = LINE_W / BEAT_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0, d_addr = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] i_rdata, d_rdata;
  logic              i_resp, d_resp, pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [BEAT_W-1:0] pmem_wdata;
  logic [BEAT_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  typedef struct {
    bit                is_d;
    bit                is_wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] line;
  } exp_t;

  exp_t              sb[$];
  exp_t              cur;
  logic [LINE_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [LINE_W-1:0] tmp_line, line1, line_i7;
  int                n_chk = 0, n_pass = 0;
  int                mcnt = 0, lat, exp_lat;
  bit                gaps = 0, stray = 0, hold = 0;
  bit                r_isd, r_iswr;
  logic [ADDR_W-1:0] r_addr;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [LINE_W-1:0] get_line(input logic [ADDR_W-1:0] a);
    if (!mem.exists(a))
      mem[a] = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    return mem[a];
  endfunction

  task automatic issue(input bit is_d, input bit is_wr, input logic [ADDR_W-1:0] a,
                       input logic [LINE_W-1:0] wd);
    exp_t e;
    e.is_d  = is_d;
    e.is_wr = is_wr;
    e.addr  = {a[ADDR_W-1:5], 5'b0};
    e.line  = is_wr ? wd : get_line(e.addr);
    sb.push_back(e);
    if (is_d) begin
      d_addr  = a;
      d_wdata = wd;
      if (is_wr) d_write = 1'b1; else d_read = 1'b1;
    end else begin
      i_addr = a;
      i_read = 1'b1;
    end
  endtask

  // Cycle 1 is the cycle the request is driven in; returns the cycle the resp shows up in.
  task automatic run_lat(input bit is_d, output int l);
    l = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (is_d ? d_resp : i_resp) break;
      @(posedge clk);
      l++;
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk({tag, "_pending"}, sb.size(), 0);
    if (sb.size() != 0) begin
      sb.delete();
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  // Memory model plus response scoreboard, all sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      mcnt = 0;
      pmem_resp = 1'b0;
      continue;
    end
    if (i_resp || d_resp) begin
      if (sb.size() == 0) chk("unexpected_resp", {i_resp, d_resp}, 2'b00);
      else begin
        cur = sb.pop_front();
        chk("resp_src", {i_resp, d_resp}, cur.is_d ? 2'b01 : 2'b10);
        if (!cur.is_wr) chk("rdata", cur.is_d ? d_rdata : i_rdata, cur.line);
        chk("pmem_idle_at_resp", {pmem_read, pmem_write}, 2'b00);
        if (!hold) begin
          if (i_resp) i_read = 1'b0;
          if (d_resp) begin d_read = 1'b0; d_write = 1'b0; end
        end else if (sb.size() == 0) begin
          i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        end
      end
    end
    if ((pmem_read || pmem_write) && sb.size() != 0) begin
      if (gaps && $urandom_range(0, 2) == 0) pmem_resp = 1'b0;
      else begin
        cur = sb[0];
        chk("pmem_addr", pmem_addr, cur.addr);
        chk("pmem_mode", {pmem_read, pmem_write}, cur.is_wr ? 2'b01 : 2'b10);
        if (cur.is_wr) begin
          chk("pmem_wdata", pmem_wdata, cur.line[mcnt*BEAT_W +: BEAT_W]);
          tmp_line = get_line(cur.addr);
          tmp_line[mcnt*BEAT_W +: BEAT_W] = pmem_wdata;
          mem[cur.addr] = tmp_line;
        end else begin
          tmp_line = mem[cur.addr];
          pmem_rdata = tmp_line[mcnt*BEAT_W +: BEAT_W];
        end
        pmem_resp = 1'b1;
        mcnt = (mcnt + 1) % BEATS;
      end
    end else begin
      if (pmem_read || pmem_write) chk("unexpected_burst", {pmem_read, pmem_write}, 2'b00);
      pmem_resp  = stray;
      pmem_rdata = stray ? '1 : '0;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pmem_rw", {pmem_read, pmem_write}, 2'b00);
    chk("rst_resp", {i_resp, d_resp}, 2'b00);
    chk("rst_pmem_addr", pmem_addr, 0);
    chk("rst_line", i_rdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // I read alone; latency = request cycle + BEATS beats + DONE
    line1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    mem[32'h0000_1220] = line1;
    issue(0, 0, 32'h0000_1234, '0);
    run_lat(0, lat);
    chk("i_latency", lat, BEATS + 2);
    wait_done("t_iread", 200);

    // D writeback; the line buffer must not be touched by write beats
    issue(1, 1, 32'h8000_0040, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
    wait_done("t_dwrite", 200);
    chk("rdata_hold_after_wr", d_rdata, line1);

    // contention: default D first; with fairness the last grant was D, so I first
`ifdef ARB_FAIRNESS_EN
    issue(0, 0, 32'h0000_3000, '0);
    issue(1, 0, 32'h0000_2000, '0);
    exp_lat = BEATS + 2;
`else
    issue(1, 0, 32'h0000_2000, '0);
    issue(0, 0, 32'h0000_3000, '0);
    exp_lat = 2 * (BEATS + 2);
`endif
    run_lat(0, lat);
    chk("i_contention_latency", lat, exp_lat);
    wait_done("t_contend", 300);

`ifdef ARB_FAIRNESS_EN
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    hold = 1;
    issue(1, 0, 32'h0000_5000, '0);
    issue(0, 0, 32'h0000_4000, '0);
    issue(1, 0, 32'h0000_5000, '0);
    issue(0, 0, 32'h0000_4000, '0);
    wait_done("t_fair", 400);
    hold = 0;
`endif

    // async reset after two beats of a D read
    issue(1, 0, 32'h0000_6000, '0);
    for (int k = 0; k < 50 && mcnt != 2; k++) @(negedge clk);
    chk("mid_burst_reached", mcnt, 2);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_pmem_read", pmem_read, 1'b0);
    chk("rst_mid_resp", {i_resp, d_resp}, 2'b00);
    chk("rst_mid_line", d_rdata, 0);
    sb.delete();
    d_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(1, 0, 32'h0000_6040, '0);
    wait_done("t_after_rst", 200);

    // stray pmem_resp while IDLE must not start anything or move the counter
    stray = 1;
    repeat (4) @(posedge clk);
    #1;
    chk("stray_pmem_rw", {pmem_read, pmem_write}, 2'b00);
    chk("stray_resp", {i_resp, d_resp}, 2'b00);
    stray = 0;
    @(posedge clk); #1;
    issue(0, 0, 32'h0000_7000, '0);
    wait_done("t_after_stray", 200);
    line_i7 = mem[32'h0000_7000];

    // d_read and d_write together: the write is served
    issue(1, 1, 32'h0000_7100, {$urandom(), $urandom(), $urandom(), $urandom(),
                                $urandom(), $urandom(), $urandom(), $urandom()});
    d_read = 1'b1;
    wait_done("t_rd_wr_both", 200);
    chk("both_keeps_line", d_rdata, line_i7);

    // random single-requester traffic with memory wait states
    gaps = 1;
    for (int k = 0; k < 8; k++) begin
      r_isd  = 1'($urandom_range(0, 1));
      r_iswr = r_isd && ($urandom_range(0, 1) == 1);
      r_addr = 32'h0000_9000 + 32'($urandom_range(0, 3) * 32) + 32'($urandom_range(0, 31));
      issue(r_isd, r_iswr, r_addr, {$urandom(), $urandom(), $urandom(), $urandom(),
                                    $urandom(), $urandom(), $urandom(), $urandom()});
      wait_done("t_rand", 300);
    end
    gaps = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares one burst physical-memory port between the instruction cache (read-only) and the data cache (read/write).
- Sits between the pipeline's I/D caches and main memory.
- Converts whole-line requests into fixed-length beat bursts and returns whole lines.
- Stalls on the non-granted side surface to the pipeline as mem_delay_stall through the held (unacknowledged) request.

Parameters:
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, physical memory beat width in bits; BEATS = LINE_W/BEAT_W (default 4), must be a power of two ≥2.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_read  in  1  I-cache line read request (level, held until i_resp)
- i_addr  in  ADDR_W  I-cache request address
- i_rdata  out  LINE_W  returned I line
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request (level)
- d_write  in  1  D-cache line writeback request (level)
- d_addr  in  ADDR_W  D-cache request address
- d_wdata  in  LINE_W  D line to write
- d_rdata  out  LINE_W  returned D line
- d_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  memory burst read active
- pmem_write  out  1  memory burst write active
- pmem_addr  out  ADDR_W  line-aligned burst address
- pmem_wdata  out  BEAT_W  current write beat
- pmem_rdata  in  BEAT_W  current read beat
- pmem_resp  in  1  beat accepted/valid, one per beat

Behaviour:
- States: IDLE, I_RD, D_RD, D_WR, DONE.
- Reset (any time, including mid-burst): state=IDLE, beat counter=0, all resp/pmem_read/pmem_write=0, pmem_addr=0, line buffer=0, fairness bit=0. An interrupted burst is abandoned; no resp is issued.
- IDLE: samples requests each cycle; grant takes effect next cycle (1-cycle arbitration latency). No request: stay IDLE.
- Priority without fairness: D over I. Within D, d_write beats d_read; both asserted together is a protocol error (assertion fires, write served).
- Grant latches the selected address as {addr[ADDR_W-1:log2(LINE_W/8)], zeros}. pmem_addr is held stable for the whole burst.
- I_RD / D_RD:
  - pmem_read=1.
  - On each pmem_resp, pmem_rdata is written into line-buffer slice [cnt*BEAT_W +: BEAT_W] and cnt increments.
  - After the beat where cnt==BEATS-1: goto DONE, cnt wraps to 0.
- D_WR:
  - pmem_write=1, pmem_wdata = d_wdata[cnt*BEAT_W +: BEAT_W] (combinational from cnt).
  - Counts and transitions the same way as reads.
- pmem_read/pmem_write drop in the cycle after the last pmem_resp and are never both 1.
- DONE:
  - Exactly one cycle. Pulses i_resp or d_resp for the served requester; the other resp stays 0.
  - For reads, i_rdata/d_rdata = line buffer; the value holds until the next read into the same buffer.
  - Then IDLE. A request still asserted in the same cycle as resp is treated as the consumer's next request only if still high in IDLE.
- End-to-end read latency: grant(1) + BEATS memory beats + DONE(1).
- Requester dropping its request mid-burst: the burst completes anyway and resp still pulses.
- pmem_resp while IDLE/DONE: ignored.

Optional Feature:
- Macro ARB_FAIRNESS_EN.
- Defined: a 1-bit last_grant register (0=I, 1=D) is updated at each grant. When I and D both request in IDLE, the side not served last is granted, guaranteeing alternation under contention.
- Undefined: fixed D-over-I priority; the register is not instantiated.

Decomposition:
- Package arb_types:
  - arb_state_t enum (IDLE, I_RD, D_RD, D_WR, DONE).
  - arb_src_t enum (src_i, src_d).
  - Constants LINE_W, BEAT_W, BEATS, OFFSET_BITS.
- Sub-module line_burst_buf:
  - Beat counter plus line buffer.
  - Inputs: clr, beat_valid, beat_in, wline; outputs: last_beat, line_out, beat_out.
  - Reused by the future L2 interface.

Test Plan:
- I read alone, i_addr=0x0000_1234, memory beats 0x11..,0x22..,0x33..,0x44.. -> pmem_addr=0x0000_1220; i_rdata={beat3,beat2,beat1,beat0}; i_resp pulses once, BEATS+2 cycles after request.
- D write, d_addr=0x8000_0040, d_wdata=256'h4444..3333..2222..1111.. -> pmem_wdata sequence 0x1111..,0x2222..,0x3333..,0x4444..; pmem_write deasserts after beat 4; d_resp one pulse; i_resp=0.
- I and D read asserted same cycle, fairness undefined -> D served first; then I served; I sees one extra burst of latency.
- Fairness defined, I and D held continuously for 4 transactions -> grant order alternates D,I,D,I.
- rst asserted after beat 2 of a D read -> pmem_read=0 immediately (async); no d_resp; next request starts with cnt=0 and a correct line.
- pmem_resp pulsed in IDLE, plus d_read&d_write together -> IDLE stray beat ignored (state unchanged); the simultaneous case serves the write and the assertion fires.
